// File: rtl/v_lane_valid_gen_if.sv
// Operation/beat handshake bundle for v_lane_valid_gen: the control block drives the master side,
// the lane mask generator sits on the slave side.
interface v_lane_valid_gen_if #(
   parameter int unsigned VLANE_NUM       = 8,
   parameter int unsigned MAX_VL_PER_LANE = 256
);
   localparam int unsigned VL_W = $clog2(VLANE_NUM * MAX_VL_PER_LANE) + 1;

   logic                 load_i;
   logic [VL_W-1:0]      vl_i;
   logic [VL_W-1:0]      vstart_i;
   logic                 vm_i;
   logic                 reduce_i;
   logic                 shift_en_i;
   logic [VLANE_NUM-1:0] v0_mask_i;
   logic                 shift_partial_i;
   logic [VLANE_NUM-1:0] valid_o;
   logic [VLANE_NUM-1:0] active_o;
   logic                 last_beat_o;
   logic                 partial_valid_o;
   logic                 busy_o;
   logic                 done_o;

   modport master (
      output load_i, vl_i, vstart_i, vm_i, reduce_i, shift_en_i, v0_mask_i, shift_partial_i,
      input  valid_o, active_o, last_beat_o, partial_valid_o, busy_o, done_o
   );

   modport slave (
      input  load_i, vl_i, vstart_i, vm_i, reduce_i, shift_en_i, v0_mask_i, shift_partial_i,
      output valid_o, active_o, last_beat_o, partial_valid_o, busy_o, done_o
   );
endinterface

// File: rtl/v_lane_valid_gen.sv
// Per-beat lane valid/active mask generator with vstart/vl bounds, v0 masking and a
// reduction drain of per-lane partial-result valids.
module v_lane_valid_gen #(
   parameter int unsigned VLANE_NUM       = 8,
   parameter int unsigned MAX_VL_PER_LANE = 256
) (
   input logic               clk_i,
   input logic               rstn_i,
   v_lane_valid_gen_if.slave bus
);
   localparam int unsigned VL_W  = $clog2(VLANE_NUM * MAX_VL_PER_LANE) + 1;
   localparam int unsigned LogN  = $clog2(VLANE_NUM);
   localparam int unsigned BeatW = VL_W - LogN;
   localparam int unsigned CntW  = LogN;
   localparam logic [CntW-1:0] LastShift = CntW'(VLANE_NUM - 2);

   typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

   state_e               state_q, state_d;
   logic [VL_W-1:0]      vl_q, vl_d;
   logic [VL_W-1:0]      vstart_q, vstart_d;
   logic                 vm_q, vm_d;
   logic                 red_q, red_d;
   logic [BeatW-1:0]     beat_q, beat_d;
   logic [VLANE_NUM-2:0] pv_q, pv_d;
   logic [CntW-1:0]      cnt_q, cnt_d;

   logic [VL_W:0]        end_beat_full;
   logic [BeatW-1:0]     end_beat;
   logic                 beat_fire;
   logic                 at_end;
   logic [VLANE_NUM-1:0] in_body;
   logic [VLANE_NUM-1:0] valid;
   logic [VLANE_NUM-1:0] active;

   // Ceil-divide at VL_W+1 bits so a full-range vl cannot wrap.
   assign end_beat_full = ({1'b0, vl_q} + (VL_W+1)'(VLANE_NUM - 1)) >> LogN;
   assign end_beat      = BeatW'(end_beat_full - (VL_W+1)'(1));
   assign beat_fire     = (state_q == StRun) && bus.shift_en_i;
   assign at_end        = (beat_q == end_beat);

   for (genvar i = 0; i < VLANE_NUM; i++) begin : g_lane
      logic [VL_W:0] idx;
      assign idx        = {1'b0, beat_q, LogN'(i)};
      assign in_body[i] = (idx >= {1'b0, vstart_q}) && (idx < {1'b0, vl_q});
   end

   assign valid  = beat_fire ? in_body : '0;
   assign active = valid & (vm_q ? {VLANE_NUM{1'b1}} : bus.v0_mask_i);

   assign bus.valid_o         = valid;
   assign bus.active_o        = active;
   assign bus.last_beat_o     = beat_fire && at_end;
   assign bus.partial_valid_o = (state_q == StDrain) && pv_q[0];
   assign bus.busy_o          = (state_q != StIdle);
   assign bus.done_o          = (state_q == StDone);

   always_comb begin
      state_d  = state_q;
      vl_d     = vl_q;
      vstart_d = vstart_q;
      vm_d     = vm_q;
      red_d    = red_q;
      beat_d   = beat_q;
      pv_d     = pv_q;
      cnt_d    = cnt_q;
      if (bus.load_i) begin
         // A load restarts from any state and takes priority over beat/drain shifts.
         vl_d     = bus.vl_i;
         vstart_d = bus.vstart_i;
         vm_d     = bus.vm_i;
         red_d    = bus.reduce_i;
         beat_d   = BeatW'(bus.vstart_i >> LogN);
         pv_d     = '0;
         cnt_d    = '0;
         state_d  = (bus.vl_i > bus.vstart_i) ? StRun : StDone;
      end else begin
         case (state_q)
            StIdle: ;
            StRun: begin
               if (bus.shift_en_i) begin
                  pv_d = pv_q | active[VLANE_NUM-1:1];
                  if (at_end) begin
                     state_d = red_q ? StDrain : StDone;
                  end else begin
                     beat_d = beat_q + BeatW'(1);
                  end
               end
            end
            StDrain: begin
               if (bus.shift_partial_i) begin
                  pv_d  = pv_q >> 1;
                  cnt_d = cnt_q + CntW'(1);
                  if (cnt_q == LastShift) state_d = StDone;
               end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state_q  <= StIdle;
         vl_q     <= '0;
         vstart_q <= '0;
         vm_q     <= 1'b0;
         red_q    <= 1'b0;
         beat_q   <= '0;
         pv_q     <= '0;
         cnt_q    <= '0;
      end else begin
         state_q  <= state_d;
         vl_q     <= vl_d;
         vstart_q <= vstart_d;
         vm_q     <= vm_d;
         red_q    <= red_d;
         beat_q   <= beat_d;
         pv_q     <= pv_d;
         cnt_q    <= cnt_d;
      end
   end

`ifndef SYNTHESIS
   a_vl_legal : assert property (@(posedge clk_i) disable iff (!rstn_i)
      bus.load_i |-> (bus.vl_i <= VL_W'(VLANE_NUM * MAX_VL_PER_LANE)));
`endif
endmodule

// File: tb/tb_v_lane_valid_gen.sv
// Bench for v_lane_valid_gen: directed vector table, hand-written restart/reset sequences and
// random traffic, all checked cycle-by-cycle against an element-level reference model.
module tb_v_lane_valid_gen;
   localparam int unsigned N    = 8;
   localparam int unsigned MAXV = 256;
   localparam int unsigned VL_W = $clog2(N * MAXV) + 1;

   logic clk_i  = 1'b0;
   logic rstn_i = 1'b0;
   always #5 clk_i = ~clk_i;

   v_lane_valid_gen_if #(.VLANE_NUM(N), .MAX_VL_PER_LANE(MAXV)) bus ();

   v_lane_valid_gen #(.VLANE_NUM(N), .MAX_VL_PER_LANE(MAXV)) dut (
      .clk_i  (clk_i),
      .rstn_i (rstn_i),
      .bus    (bus)
   );

   int errors = 0;
   int checks = 0;

   // Reference model: 0 idle, 1 running beats, 2 draining, 3 done.
   int m_st, m_vl, m_vs, m_beat, m_last, m_k;
   bit m_vm, m_red;
   bit m_seen[N];

   logic [N-1:0] obs_valid, obs_active;
   logic         obs_last, obs_pv, obs_busy, obs_done;

   typedef struct {
      int         vl;
      int         vs;
      bit         vm;
      bit         red;
      logic [7:0] v0a;
      logic [7:0] v0b;
      int         beats;
      logic [7:0] first;
      logic [7:0] last;
      logic [7:0] act0;
      logic [7:0] act1;
      logic [7:0] drain;
      int         busy;
   } vec_t;

   vec_t tbl[8];

   int         r_beats, r_busy, r_done;
   logic [7:0] r_first, r_last, r_act0, r_act1, r_drain;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_vl = 0; m_vs = 0; m_beat = 0; m_last = 0; m_k = 0;
      m_vm = 1'b0; m_red = 1'b0;
      for (int l = 0; l < N; l++) m_seen[l] = 1'b0;
   endtask

   // Called just after a falling edge; checks outputs then advances one clock.
   task automatic step(input bit ld, input int vl, input int vs, input bit vm, input bit red,
                       input bit se, input logic [N-1:0] v0, input bit sp);
      logic [N-1:0] ev, ea;
      bit           fire, el, epv;
      int           idx;
      bus.load_i          = ld;
      bus.vl_i            = VL_W'(vl);
      bus.vstart_i        = VL_W'(vs);
      bus.vm_i            = vm;
      bus.reduce_i        = red;
      bus.shift_en_i      = se;
      bus.v0_mask_i       = v0;
      bus.shift_partial_i = sp;
      #1;
      fire = (m_st == 1) && se;
      for (int l = 0; l < N; l++) begin
         idx   = m_beat * N + l;
         ev[l] = fire && (idx >= m_vs) && (idx < m_vl);
         ea[l] = ev[l] && (m_vm || v0[l]);
      end
      el  = fire && (m_beat == m_last);
      epv = (m_st == 2) && (m_k < N - 1) && m_seen[m_k + 1];
      obs_valid  = bus.valid_o;
      obs_active = bus.active_o;
      obs_last   = bus.last_beat_o;
      obs_pv     = bus.partial_valid_o;
      obs_busy   = bus.busy_o;
      obs_done   = bus.done_o;
      check("outputs{valid,active,last,pv,busy,done}",
            32'({obs_valid, obs_active, obs_last, obs_pv, obs_busy, obs_done}),
            32'({ev, ea, el, epv, m_st != 0, m_st == 3}));
      @(posedge clk_i);
      if (ld) begin
         m_vl = vl; m_vs = vs; m_vm = vm; m_red = red;
         m_beat = vs / N;
         m_last = (vl + N - 1) / N - 1;
         m_k = 0;
         for (int l = 0; l < N; l++) m_seen[l] = 1'b0;
         m_st = (vl > vs) ? 1 : 3;
      end else begin
         case (m_st)
            1: if (se) begin
                  for (int l = 1; l < N; l++) if (ea[l]) m_seen[l] = 1'b1;
                  if (m_beat == m_last) m_st = m_red ? 2 : 3;
                  else m_beat++;
               end
            2: if (sp) begin
                  m_k++;
                  if (m_k == N - 1) m_st = 3;
               end
            3: m_st = 0;
            default: ;
         endcase
      end
      @(negedge clk_i);
   endtask

   // Loads one op, then streams beats and drain shifts every cycle until done_o.
   task automatic run_op(input int vl, input int vs, input bit vm, input bit red,
                         input logic [7:0] v0a, input logic [7:0] v0b);
      bit fin, after_last;
      int drain_i;
      r_beats = 0; r_busy = 0; r_done = 0;
      r_first = '0; r_last = '0; r_act0 = '0; r_act1 = '0; r_drain = '0;
      fin = 1'b0; after_last = 1'b0; drain_i = 0;
      step(1'b1, vl, vs, vm, red, 1'b0, '0, 1'b0);
      for (int c = 0; c < 300 && !fin; c++) begin
         step(1'b0, vl, vs, vm, red, 1'b1, r_beats[0] ? v0b : v0a, 1'b1);
         if (obs_busy) r_busy++;
         if (obs_valid != '0) begin
            if (r_beats == 0) begin
               r_first = obs_valid;
               r_act0  = obs_active;
            end
            if (r_beats == 1) r_act1 = obs_active;
            r_beats++;
         end
         if (obs_last) begin
            r_last     = obs_valid;
            after_last = 1'b1;
         end else if (after_last && obs_busy && !obs_done && drain_i < 8) begin
            r_drain[drain_i] = obs_pv;
            drain_i++;
         end
         if (obs_done) begin
            r_done++;
            fin = 1'b1;
         end
      end
      if (!fin) check("op_timeout", 32'd1, 32'd0);
      step(1'b0, vl, vs, vm, red, 1'b1, '0, 1'b1);
      if (obs_done) r_done++;
   endtask

   int rvl, rvs, beats, dones;
   bit rvm, rred, ld;

   initial begin
      tbl[0] = '{19,   0,    1'b1, 1'b0, 8'hFF, 8'hFF, 3,   8'hFF, 8'h07, 8'hFF, 8'hFF, 8'h00, 4};
      tbl[1] = '{20,   10,   1'b1, 1'b0, 8'hFF, 8'hFF, 2,   8'hFC, 8'h0F, 8'hFC, 8'h0F, 8'h00, 3};
      tbl[2] = '{16,   0,    1'b0, 1'b0, 8'hAA, 8'h0F, 2,   8'hFF, 8'hFF, 8'hAA, 8'h0F, 8'h00, 3};
      tbl[3] = '{3,    0,    1'b1, 1'b1, 8'hFF, 8'hFF, 1,   8'h07, 8'h07, 8'h07, 8'h00, 8'h03, 9};
      tbl[4] = '{0,    0,    1'b1, 1'b0, 8'hFF, 8'hFF, 0,   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1};
      tbl[5] = '{5,    5,    1'b1, 1'b0, 8'hFF, 8'hFF, 0,   8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1};
      tbl[6] = '{2048, 0,    1'b1, 1'b0, 8'hFF, 8'hFF, 256, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 257};
      tbl[7] = '{2048, 2047, 1'b1, 1'b1, 8'hFF, 8'hFF, 1,   8'h80, 8'h80, 8'h80, 8'h00, 8'h40, 9};

      model_reset();
      bus.load_i = 1'b0; bus.vl_i = '0; bus.vstart_i = '0; bus.vm_i = 1'b0; bus.reduce_i = 1'b0;
      bus.shift_en_i = 1'b1; bus.v0_mask_i = '1; bus.shift_partial_i = 1'b1;
      #1;
      check("reset_state", 32'({bus.valid_o, bus.active_o, bus.last_beat_o, bus.partial_valid_o,
                                bus.busy_o, bus.done_o}), 32'd0);
      @(negedge clk_i);
      @(negedge clk_i);
      rstn_i = 1'b1;

      for (int i = 0; i < 8; i++) begin
         run_op(tbl[i].vl, tbl[i].vs, tbl[i].vm, tbl[i].red, tbl[i].v0a, tbl[i].v0b);
         check($sformatf("vec%0d_beats", i), 32'(r_beats), 32'(tbl[i].beats));
         check($sformatf("vec%0d_first_valid", i), 32'(r_first), 32'(tbl[i].first));
         check($sformatf("vec%0d_last_valid", i), 32'(r_last), 32'(tbl[i].last));
         check($sformatf("vec%0d_active0", i), 32'(r_act0), 32'(tbl[i].act0));
         check($sformatf("vec%0d_active1", i), 32'(r_act1), 32'(tbl[i].act1));
         check($sformatf("vec%0d_drain_seq", i), 32'(r_drain), 32'(tbl[i].drain));
         check($sformatf("vec%0d_busy_cycles", i), 32'(r_busy), 32'(tbl[i].busy));
         check($sformatf("vec%0d_done_count", i), 32'(r_done), 32'd1);
      end

      // Restart mid-RUN: 4-beat op reloaded at beat 1 with an 8-element op.
      step(1'b1, 32, 0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      step(1'b0, 32, 0, 1'b1, 1'b0, 1'b1, '0, 1'b0);
      step(1'b1, 8, 0, 1'b1, 1'b0, 1'b0, '0, 1'b0);
      beats = 0; dones = 0;
      for (int c = 0; c < 6; c++) begin
         step(1'b0, 8, 0, 1'b1, 1'b0, 1'b1, '0, 1'b0);
         if (obs_valid == 8'hFF) beats++;
         if (obs_done) dones++;
      end
      check("reload_beats", 32'(beats), 32'd1);
      check("reload_done_count", 32'(dones), 32'd1);

      // Async reset in the middle of a reduction drain.
      step(1'b1, 3, 0, 1'b1, 1'b1, 1'b0, '0, 1'b0);
      step(1'b0, 3, 0, 1'b1, 1'b1, 1'b1, '0, 1'b0);
      step(1'b0, 3, 0, 1'b1, 1'b1, 1'b0, '0, 1'b1);
      #1;
      check("pre_reset_pv", 32'(bus.partial_valid_o), 32'd1);
      rstn_i = 1'b0;
      #1;
      check("mid_drain_reset", 32'({bus.valid_o, bus.active_o, bus.last_beat_o,
                                    bus.partial_valid_o, bus.busy_o, bus.done_o}), 32'd0);
      model_reset();
      @(negedge clk_i);
      rstn_i = 1'b1;
      for (int c = 0; c < 3; c++) step(1'b0, 3, 0, 1'b1, 1'b1, 1'b1, '1, 1'b1);

      rvl = 0; rvs = 0; rvm = 1'b1; rred = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         ld = (m_st == 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 59) == 0);
         if (ld) begin
            case ($urandom_range(0, 3))
               0:       rvl = $urandom_range(0, 40);
               1:       rvl = $urandom_range(0, 2048);
               2:       rvl = 2048;
               default: rvl = $urandom_range(0, 100);
            endcase
            rvs  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, rvl + 9)
                                               : $urandom_range(0, rvl / 2);
            rvm  = $urandom_range(0, 1) == 1;
            rred = $urandom_range(0, 1) == 1;
         end
         step(ld, rvl, rvs, rvm, rred, !ld && ($urandom_range(0, 3) != 0),
              N'($urandom), $urandom_range(0, 1) == 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
